// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared widths, NOP encoding and fetch FSM states
package fetch_pc_unit_pkg;

  localparam int PC_SIZE     = 32;
  localparam int INSTR_SIZE  = 32;
  localparam int OPCODE_SIZE = 7;

  localparam logic [INSTR_SIZE-1:0] NOP_ENCODING = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [PC_SIZE-1:0] align_pc(input logic [PC_SIZE-1:0] addr);
    return {addr[PC_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry instruction/PC holding register
module fetch_skid_buffer
  import fetch_pc_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [INSTR_SIZE-1:0] load_instr,
  input  logic [PC_SIZE-1:0]    load_pc,
  output logic                  valid,
  output logic [INSTR_SIZE-1:0] instr,
  output logic [PC_SIZE-1:0]    pc
);

  logic                  valid_q, valid_d;
  logic [INSTR_SIZE-1:0] instr_q, instr_d;
  logic [PC_SIZE-1:0]    pc_q, pc_d;

  // load wins over clear so a same-cycle refill is never lost
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC, single-outstanding imem requests, IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [PC_SIZE-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  output logic                   imem_req,
  output logic [PC_SIZE-1:0]     imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_SIZE-1:0]  imem_rdata,
  input  logic [PC_SIZE-1:0]     bpu_npc,
  input  logic                   bpu_mux_sel,
  input  logic                   bpu_chng2nop,
  output logic [PC_SIZE-1:0]     pc,
  output logic [PC_SIZE-1:0]     pcplf,
  output logic [OPCODE_SIZE-1:0] op,
  output logic                   pc_en,
  output logic                   ifid_valid,
  output logic [INSTR_SIZE-1:0]  ifid_instr,
  output logic [PC_SIZE-1:0]     ifid_pc,
  output logic [PC_SIZE-1:0]     ifid_pcplf
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_squashed,
  output logic [31:0]            perf_stall
`endif
);

  fetch_state_e          state_q, state_d;
  logic [PC_SIZE-1:0]    pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [PC_SIZE-1:0]    drop_addr_q, drop_addr_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic [INSTR_SIZE-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_SIZE-1:0]    ifid_pc_q, ifid_pc_d;
  logic [PC_SIZE-1:0]    ifid_pcplf_q, ifid_pcplf_d;

  logic                  accept;
  logic                  skid_load, skid_clear, skid_valid;
  logic [INSTR_SIZE-1:0] skid_instr, src_instr;
  logic [PC_SIZE-1:0]    skid_pc, src_pc;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    drop_addr_d  = drop_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pcplf_d = ifid_pcplf_q;
    accept       = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    src_instr    = imem_rdata;
    src_pc       = pc_q;

    case (state_q)
      BOOT: begin
        state_d = WAIT;
        if (imem_rvalid) begin
          drop_d = 1'b0;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (stall) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            accept = 1'b1;
          end
        end else if (bpu_mux_sel) begin
          // keep presenting the in-flight address until its response is discarded
          pc_d   = align_pc(bpu_npc);
          drop_d = 1'b1;
          if (!drop_q) begin
            drop_addr_d = pc_q;
          end
        end
      end
      HOLD: begin
        if (!stall && skid_valid) begin
          accept     = 1'b1;
          src_instr  = skid_instr;
          src_pc     = skid_pc;
          skid_clear = 1'b1;
          state_d    = WAIT;
        end
      end
      default: state_d = BOOT;
    endcase

    if (accept) begin
      pc_d         = align_pc(bpu_mux_sel ? bpu_npc : pc_q + PC_SIZE'(4));
      ifid_valid_d = 1'b1;
      ifid_instr_d = bpu_chng2nop ? NOP_INSTR : src_instr;
      ifid_pc_d    = src_pc;
      ifid_pcplf_d = src_pc + PC_SIZE'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= align_pc(RESET_PC);
      drop_q       <= (state_q == WAIT);
      drop_addr_q  <= align_pc(RESET_PC);
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pcplf_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      drop_addr_q  <= drop_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcplf_q <= ifid_pcplf_d;
    end
  end

  assign imem_req   = (state_q == WAIT);
  assign imem_addr  = drop_q ? drop_addr_q : pc_q;
  assign pc         = pc_q;
  assign pcplf      = pc_q + PC_SIZE'(4);
  assign pc_en      = accept && !rst;
  assign op         = (state_q == HOLD) ? skid_instr[OPCODE_SIZE-1:0]
                    : (imem_rvalid ? imem_rdata[OPCODE_SIZE-1:0] : '0);
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pcplf = ifid_pcplf_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] squashed_q, squashed_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetched_d   = fetched_q;
    squashed_d  = squashed_q;
    stall_cnt_d = stall_cnt_q;
    if (pc_en && (fetched_q != '1)) begin
      fetched_d = fetched_q + 32'd1;
    end
    if (pc_en && bpu_chng2nop && (squashed_q != '1)) begin
      squashed_d = squashed_q + 32'd1;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q   <= '0;
      squashed_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetched_q   <= fetched_d;
      squashed_q  <= squashed_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
  assign perf_stall    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, imem_req, imem_rvalid, bpu_mux_sel, bpu_chng2nop, pc_en, ifid_valid;
  logic [31:0] imem_addr, imem_rdata, bpu_npc, pc, pcplf, ifid_instr, ifid_pc, ifid_pcplf;
  logic [6:0]  op;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed, perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .bpu_npc(bpu_npc), .bpu_mux_sel(bpu_mux_sel), .bpu_chng2nop(bpu_chng2nop),
    .pc(pc), .pcplf(pcplf), .op(op), .pc_en(pc_en),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pcplf(ifid_pcplf)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed), .perf_stall(perf_stall)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] addr);
    if (addr == 32'h0000_000C) return 32'h00A0_0093;
    return {addr[24:0], 7'h33};
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  op;
  } ifid_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        sel;
    logic [31:0] npc;
    logic        nop;
    int          stall_n;
  } vec_t;

  ifid_exp_t   exp_ifid_q[$];
  logic [31:0] exp_addr_q[$];
  vec_t        vecs[$];

  int          lat = 0;
  bit          mem_on = 1'b0;

  // memory: accepts a held request when idle, answers after lat cycles (0 = same cycle)
  initial begin
    bit          busy = 1'b0;
    int          busy_cnt = 0;
    logic [31:0] busy_addr = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (busy) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word(busy_addr);
          busy        = 1'b0;
        end
      end else if (mem_on && imem_req) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word(imem_addr);
        end else begin
          busy      = 1'b1;
          busy_cnt  = lat;
          busy_addr = imem_addr;
        end
      end
    end
  end

  // monitor: every pc_en pops one expected instruction; IF/ID is compared a cycle later
  initial begin
    bit        pend = 1'b0;
    ifid_exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (pend) begin
        chk("ifid_valid", 32'(ifid_valid), 32'd1);
        chk("ifid_pc", ifid_pc, cur.pc);
        chk("ifid_instr", ifid_instr, cur.instr);
        chk("ifid_pcplf", ifid_pcplf, cur.pc + 32'd4);
        pend = 1'b0;
      end
      if (pc_en) begin
        if (exp_ifid_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pc_en: got pc_en=1 at pc %h expected 0", pc);
        end else begin
          cur = exp_ifid_q.pop_front();
          chk("accept_pc", pc, cur.pc);
          chk("accept_pcplf", pcplf, cur.pc + 32'd4);
          chk("accept_op", 32'(op), 32'(cur.op));
          pend = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_bpu();
    bpu_mux_sel  = 1'b0;
    bpu_chng2nop = 1'b0;
    bpu_npc      = '0;
  endtask

  task automatic addv(input logic [31:0] addr, input logic sel, input logic [31:0] npc,
                      input logic nop, input int stall_n);
    vecs.push_back('{addr, sel, npc, nop, stall_n});
  endtask

  task automatic run_vectors();
    logic [31:0] w;
    foreach (vecs[i]) begin
      w = word(vecs[i].addr);
      exp_addr_q.push_back(vecs[i].addr);
      exp_ifid_q.push_back('{vecs[i].addr, vecs[i].nop ? NOP_ENCODING : w, w[6:0]});
    end
    lat    = 0;
    mem_on = 1'b1;
    foreach (vecs[i]) begin
      int n   = 0;
      bit got = 1'b0;
      while (!got && n < 20) begin
        tick();
        clear_bpu();
        stall = 1'b0;
        if (imem_req && imem_rvalid) got = 1'b1;
        n++;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout: got no response expected one at %h", vecs[i].addr);
      end
      if (vecs[i].stall_n > 0) begin
        stall = 1'b1;
        repeat (vecs[i].stall_n - 1) begin
          tick();
          chk("hold_req", 32'(imem_req), 32'd0);
          chk("hold_pc_en", 32'(pc_en), 32'd0);
          if (i > 0) chk("hold_ifid_pc", ifid_pc, vecs[i-1].addr);
        end
        tick();
        stall = 1'b0;
      end
      bpu_mux_sel  = vecs[i].sel;
      bpu_npc      = vecs[i].npc;
      bpu_chng2nop = vecs[i].nop;
      if (i == vecs.size() - 1) mem_on = 1'b0;
    end
    tick();
    clear_bpu();
    vecs.delete();
  endtask

  // skips n responses (which must not raise pc_en), then stops the memory after the next one
  task automatic wait_resp(input int skip);
    int n   = 0;
    bit got = 1'b0;
    while (!got && n < 30) begin
      tick();
      if (imem_rvalid) begin
        if (skip > 0) begin
          chk("stale_no_pc_en", 32'(pc_en), 32'd0);
          skip--;
        end else begin
          got    = 1'b1;
          mem_on = 1'b0;
        end
      end
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_resp_timeout: got no response expected one");
    end
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    clear_bpu();
    repeat (3) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'h0000_0013);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_ifid_pcplf", ifid_pcplf, 32'h0);
    rst = 1'b0;

    // sequential, redirect, squash, stall, misaligned redirect
    addv(32'h0000_0000, 1'b0, 32'h0,         1'b0, 0);
    addv(32'h0000_0004, 1'b0, 32'h0,         1'b0, 0);
    addv(32'h0000_0008, 1'b1, 32'h0000_0100, 1'b0, 0);
    addv(32'h0000_0100, 1'b1, 32'h0000_000C, 1'b0, 0);
    addv(32'h0000_000C, 1'b0, 32'h0,         1'b1, 0);
    addv(32'h0000_0010, 1'b0, 32'h0,         1'b0, 3);
    addv(32'h0000_0014, 1'b1, 32'h0000_0203, 1'b0, 0);
    addv(32'h0000_0200, 1'b0, 32'h0,         1'b0, 0);
    run_vectors();

    // latency 3, redirect to 0x200 while 0x204 is outstanding
    exp_addr_q.push_back(32'h0000_0204);
    exp_addr_q.push_back(32'h0000_0200);
    exp_ifid_q.push_back('{32'h0000_0200, 32'h0001_0033, 7'h33});
    lat    = 3;
    mem_on = 1'b1;
    tick();
    bpu_mux_sel = 1'b1;
    bpu_npc     = 32'h0000_0200;
    tick();
    clear_bpu();
    chk("redirect_addr_stable", imem_addr, 32'h0000_0204);
    chk("redirect_req_held", 32'(imem_req), 32'd1);
    chk("redirect_pc", pc, 32'h0000_0200);
    wait_resp(1);

    // PC+4 wrap at the top of the address space
    addv(32'h0000_0204, 1'b1, 32'hFFFF_FFFC, 1'b0, 0);
    addv(32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 0);
    addv(32'h0000_0000, 1'b0, 32'h0,         1'b0, 0);
    run_vectors();

    // reset while 0x4 is outstanding; its late response must be discarded
    exp_addr_q.push_back(32'h0000_0004);
    exp_addr_q.push_back(32'h0000_0000);
    exp_ifid_q.push_back('{32'h0000_0000, 32'h0000_0033, 7'h33});
    lat    = 3;
    mem_on = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_ifid_valid", 32'(ifid_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    wait_resp(1);

    repeat (3) tick();
    chk("ifid_queue_empty", 32'(exp_ifid_q.size()), 32'd0);
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- PC generation and instruction-fetch stage, directly upstream of the branch prediction unit and the decoder.
- Holds the architectural fetch PC and computes PC+4.
- Selects the next PC between PC+4 and the BPU's npc using the BPU's mux_sel.
- Issues single-outstanding requests to instruction memory and registers the IF/ID pipeline outputs. Squashes wrong-path instructions to NOP on chng2nop.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, encoding written into IF/ID on squash (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates at posedge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  hazard stall from CU; IF/ID and PC hold.
- imem_req  out  1  fetch request valid.
- imem_addr  out  `pc_size  fetch address (word aligned).
- imem_rvalid  in  1  response valid.
- imem_rdata  in  `instr_size  fetched instruction.
- bpu_npc  in  `pc_size  predicted/corrected next PC from BPU.
- bpu_mux_sel  in  1  1 = take bpu_npc, 0 = take PC+4.
- bpu_chng2nop  in  1  squash instruction entering IF/ID.
- pc  out  `pc_size  current fetch PC (to BPU table index).
- pcplf  out  `pc_size  pc+4 (to BPU).
- op  out  `opcode_size  imem_rdata[6:0] when imem_rvalid, else 0.
- pc_en  out  1  PC advance strobe (to BPU pipeline registers).
- ifid_valid  out  1  IF/ID holds a valid instruction.
- ifid_instr  out  `instr_size  instruction to decoder.
- ifid_pc  out  `pc_size  PC of ifid_instr.
- ifid_pcplf  out  `pc_size  PC+4 of ifid_instr.

Behaviour:
- Reset values:
  - pc = RESET_PC; imem_req = 0; pc_en = 0.
  - ifid_valid = 0; ifid_instr = NOP_INSTR; ifid_pc = 0; ifid_pcplf = 0.
  - FSM = BOOT; drop flag = 0; skid buffer empty.
- Reset mid-operation:
  - Any outstanding response arriving in the cycle after rst deasserts is ignored. The drop flag is forced to 1 if rst occurred while in WAIT.
- FSM states:
  - BOOT: one cycle with imem_req=0, then → WAIT with imem_req=1, imem_addr=pc.
  - WAIT: imem_req=1 is held until imem_rvalid.
    - On rvalid && !stall: pc_en=1; pc <= bpu_mux_sel ? bpu_npc : pc+4; IF/ID loaded; stay in WAIT and issue the next address the following cycle.
    - On rvalid && stall: capture rdata/pc into the skid buffer; → HOLD.
  - HOLD: imem_req=0. When stall drops: IF/ID loaded from skid; pc_en=1; pc updated as above; → WAIT.
- Memory handshake: at most one outstanding request; imem_addr is stable while imem_req=1; rvalid without an outstanding request is ignored.
- Fetch latency is ≥1 cycle from request to IF/ID, with one instruction per cycle at zero memory wait.
- pc_en is a one-cycle pulse, asserted only in the cycle the instruction is accepted. BPU inputs pc, pcplf and op are valid in that cycle.
- Squash: if bpu_chng2nop=1 in an accept cycle, ifid_instr <= NOP_INSTR and ifid_valid <= 1. ifid_pc and ifid_pcplf still carry the squashed PC.
- Redirect while a request is outstanding: bpu_mux_sel && !pc_en in WAIT with no rvalid loads pc <= bpu_npc and sets the drop flag.
  - The next response is discarded: IF/ID unchanged, pc_en=0.
  - The request is then re-issued at the new pc.
- Simultaneous events:
  - stall has priority over accept.
  - rst has priority over everything.
  - Squash together with redirect: squash applies to the accepted instruction and the redirect applies to pc.
- Arithmetic: pcplf = pc + 4, modulo 2^`pc_size. Wrap from 32'hFFFF_FFFC to 0 is legal, with no flag.
- Misalignment: pc[1:0] is forced to 00 on every load.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, three 32-bit saturating counters are added (fetched, squashed, stall_cycles), exposed on outputs perf_fetched, perf_squashed and perf_stall. They clear on rst and increment on accept, on squash and on each stall cycle respectively.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants package: `pc_size, `instr_size, `opcode_size, NOP encoding constant, fetch FSM state enum (BOOT, WAIT, HOLD).
- One sub-module, fetch_skid_buffer: a 1-entry instruction/PC holding register with load/clear/valid.

Test Plan:
- Reset, zero-wait memory, no branches → imem_addr sequence 0x0, 0x4, 0x8; ifid_valid=1 from cycle 3; pc_en pulses every cycle.
- bpu_mux_sel=1, bpu_npc=0x100 on the accept of pc=0x8 → next imem_addr=0x100; ifid_pc sequence 0x8, 0x100.
- bpu_chng2nop=1 on the accept of pc=0xC, rdata=0x00A00093 → ifid_instr=0x00000013, ifid_pc=0xC.
- stall=1 for 3 cycles with rvalid arriving → FSM in HOLD, imem_req=0, IF/ID unchanged; on release, ifid_instr equals the buffered word and pc advances once.
- Memory latency 3, redirect to 0x200 during WAIT → stale response discarded, no pc_en; next imem_addr=0x200.
- rst asserted mid-WAIT with the response arriving after rst drops → pc=RESET_PC, ifid_valid=0, stale response ignored.
